// File: rtl/nf_ahb_ram_ctrl.sv
// nf_ahb_ram_ctrl
//   AHB-Lite slave that fronts a single-port, synchronous-read word RAM.
//   The controller generates byte-lane writes from HSIZE/HADDR and inserts
//   WAIT_ST data-phase wait states on each OKAY transfer. A read accepted
//   while the previous write pulses the RAM port costs one stall cycle.
//   Misaligned, oversize and out-of-range transfers get a two-cycle ERROR
//   response and never touch the RAM.
//
// Ports
//   hclk, hreset      clock and synchronous active-high reset
//   haddr_s .. hsel_s AHB slave side (hready_in_s is the bus HREADY,
//                     hready_s is this slave's HREADYOUT)
//   ram_addr          RAM word address
//   ram_wd, ram_we    write data (hwdata_s, not lane-shifted) and write strobe
//   ram_be            byte enables; nonzero only while ram_we is high
//   ram_re, ram_rd    read strobe, and read data valid one cycle after ram_re
//
// state | meaning
// IDLE  | no data phase in progress
// DATA  | OKAY data phase, cnt counts WAIT_ST down to 0
// RAW   | read stalled one cycle behind a write on the RAM port
// ERR1  | first ERROR cycle (hready_s low)
// ERR2  | second ERROR cycle (hready_s high)

module nf_ahb_ram_ctrl #(
  parameter int RAM_DEPTH = 256,
  parameter int WAIT_ST   = 0,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [31:0]       haddr_s,
  input  logic [31:0]       hwdata_s,
  output logic [31:0]       hrdata_s,
  input  logic              hwrite_s,
  input  logic [1:0]        htrans_s,
  input  logic [2:0]        hsize_s,
  input  logic [2:0]        hburst_s,
  output logic [1:0]        hresp_s,
  output logic              hready_s,
  input  logic              hready_in_s,
  input  logic              hsel_s,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic              ram_re
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_RAW,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_ST);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              wr_q;
  logic [31:0]       rd_q;

  logic              accept;
  logic              misalign;
  logic              out_of_range;
  logic              req_err;
  logic              rd_go;
  logic              we_slot;
  logic [3:0]        be_req;
  logic [ADDR_W-1:0] addr_req;

  // Burst type does not matter: every beat is treated as a single transfer.
  logic unused_ok;
  assign unused_ok = ^{hburst_s, htrans_s[0]};

  assign hready_s = (state == ST_IDLE) || (state == ST_ERR2) ||
                    ((state == ST_DATA) && (cnt == 4'd0));
  assign hresp_s  = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

  // Also qualified by our own HREADYOUT so a mis-wired HREADY cannot start a
  // new transfer in the middle of one of our data phases.
  assign accept = hsel_s & hready_in_s & htrans_s[1] & hready_s;

  assign misalign     = ((hsize_s == 3'd1) && haddr_s[0]) ||
                        ((hsize_s == 3'd2) && (haddr_s[1:0] != 2'b00));
  assign out_of_range = |(haddr_s >> (ADDR_W + 2));
  assign req_err      = (hsize_s > 3'd2) || misalign || out_of_range;
  assign addr_req     = haddr_s[ADDR_W+1:2];

  always_comb begin
    be_req = 4'b1111;
    case (hsize_s[1:0])
      2'd0:    be_req = 4'b0001 << haddr_s[1:0];
      2'd1:    be_req = haddr_s[1] ? 4'b1100 : 4'b0011;
      default: be_req = 4'b1111;
    endcase
  end

  // A pending write owns the RAM port in its last data cycle; a read
  // accepted in that cycle is pushed into RAW.
  assign we_slot = (state == ST_DATA) && (cnt == 4'd0) && wr_q;
  assign rd_go   = accept && !req_err && !hwrite_s;

  // Strobes are gated by reset so an aborted write never reaches the RAM.
  assign ram_we = we_slot && !hreset;
  assign ram_re = !hreset && ((rd_go && !we_slot) || (state == ST_RAW));
  assign ram_be = ram_we ? be_q : 4'b0000;
  assign ram_wd = hwdata_s;

  always_comb begin
    ram_addr = '0;
    if (ram_we || (state == ST_RAW)) begin
      ram_addr = addr_q;
    end else if (ram_re) begin
      ram_addr = addr_req;
    end
  end

  assign hrdata_s = (WAIT_ST == 0) ? ram_rd : rd_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_DATA: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
      ST_RAW: begin
        state_nxt = ST_DATA;
        cnt_nxt   = WAIT_INIT;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: ;
    endcase
    if (hready_s) begin
      if (!accept) begin
        state_nxt = ST_IDLE;
      end else if (req_err) begin
        state_nxt = ST_ERR1;
      end else if (!hwrite_s && we_slot) begin
        state_nxt = ST_RAW;
      end else begin
        state_nxt = ST_DATA;
        cnt_nxt   = WAIT_INIT;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      be_q   <= 4'd0;
      wr_q   <= 1'b0;
      rd_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // addr_q holds the write address until its pulse, then the stalled
      // read address for RAW; the two uses never overlap.
      if (accept && !req_err) begin
        addr_q <= addr_req;
        be_q   <= be_req;
        wr_q   <= hwrite_s;
      end
      if ((state == ST_DATA) && (cnt == WAIT_INIT)) begin
        rd_q <= ram_rd;
      end
    end
  end

endmodule
